spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter SS_ACT, default 8'hFE, value written to the SPI core slave-select byte during a read (active-low select of slave 0).
REQ-002 Parameter SS_IDLE, default 8'hFF, value written to the slave-select byte to release the slave.
REQ-003 Parameter RD_CMD, default 8'h03, flash read opcode.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request; sampled only when busy=0.
REQ-007 addr  in  24  flash byte address, captured on accepted start.
REQ-008 len  in  16  byte count, captured on accepted start.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse at sequence end.
REQ-011 out_data  out  8  received flash byte.
REQ-012 out_valid  out  1  out_data holds an unconsumed byte.
REQ-013 out_ready  in  1  consumer accepts; transfer occurs when out_valid&out_ready.
REQ-014 m_dat_o  out  16  Wishbone master write data to SPI core ([15:8] slave select, [7:0] tx byte).
REQ-015 m_dat_i  in  8  received byte from SPI core.
REQ-016 m_we_o  out  1  always 1 during cycles.
REQ-017 m_sel_o  out  2  byte lanes: [1] slave-select write, [0] tx byte.
REQ-018 m_stb_o, m_cyc_o  out  1 each  driven identically; a byte transfer request.
REQ-019 m_ack_i  in  1  one-cycle ack from SPI core at end of each 8-bit transfer.

Function
REQ-020 States: IDLE, CMD, A2, A1, A0, DATA, WAIT_OUT, DESEL, FIN.
REQ-021 IDLE: start=1 and len!=0 -> capture addr/len, busy=1, go CMD; start=1 and len==0 -> done pulse next cycle, no bus cycle, stay IDLE.
REQ-022 start while busy=1 is ignored.
REQ-023 Each bus transfer: stb/cyc asserted, held constant with data/sel until m_ack_i=1; stb/cyc low in the cycle following ack (min one idle cycle between transfers).
REQ-024 CMD: sel=2'b11, dat={SS_ACT,RD_CMD}; on ack go A2.
REQ-025 A2/A1/A0: sel=2'b01, dat[7:0]=addr[23:16]/[15:8]/[7:0] respectively, dat[15:8]=SS_ACT; ack advances A2->A1->A0->DATA.
REQ-026 DATA: start transfer only when out_valid=0; sel=2'b01, dat[7:0]=8'hFF; on ack load out_data<=m_dat_i, out_valid<=1, decrement remaining count.
REQ-027 After data ack: remaining count 0 -> DESEL, else WAIT_OUT.
REQ-028 WAIT_OUT: return to DATA when out_valid=0 or out_valid&out_ready in the current cycle; no bus activity meanwhile.
REQ-029 out_valid clears on out_valid&out_ready; load and consume in same cycle -> out_valid stays 1 with new data.
REQ-030 DESEL: sel=2'b10, dat={SS_IDLE,8'hFF}; on ack go FIN.
REQ-031 FIN: done=1 for one cycle, busy=0 same cycle, go IDLE; out_valid may remain 1 until consumed.
REQ-032 Remaining count 16-bit unsigned; len=16'hFFFF transfers 65535 bytes; no wrap.
REQ-033 Acks arriving with stb low are ignored.
REQ-034 Address not incremented by the block; flash auto-increments.

Reset
REQ-035 wb_rst_i=1 -> state IDLE, busy=0, done=0, out_valid=0, out_data=8'h00, m_stb_o=m_cyc_o=0, m_sel_o=2'b00, m_dat_o=16'h0000, count 0, in the next cycle.
REQ-036 Reset mid-sequence aborts immediately; no DESEL transfer issued (SPI core resets on same wb_rst_i).

Verification
REQ-037 start addr=24'h012345 len=2, out_ready=1, ack model 8 cycles -> bus bytes 03,01,23,45,FF,FF then sel=10 dat=FFFF; two out_valid pulses with model bytes; one done.
REQ-038 len=0 start -> done one cycle later, m_cyc_o never high.
REQ-039 len=3, out_ready=0 for 50 cycles after first byte -> no bus cycle while out_valid=1; resumes after ready; bytes in order.
REQ-040 start pulsed while busy -> ignored; sequence and captured addr unchanged.
REQ-041 wb_rst_i asserted during A1 -> next cycle all outputs at REQ-035 values; fresh start runs full sequence.
REQ-042 Check stb low at least one cycle between every ack and next stb assertion; CMD is the only transfer with sel=2'b11.

Source files
------------

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: streams bytes from a SPI flash through a Wishbone SPI core.
// Ports:
//   wb_clk_i, wb_rst_i      clock and synchronous active-high reset
//   start, addr, len        read request; addr/len captured when start is accepted
//   busy, done              sequence in progress / one-cycle completion pulse
//   out_data, out_valid,    received byte stream with valid/ready handshake
//   out_ready
//   m_dat_o, m_sel_o,       Wishbone master toward the SPI core:
//   m_we_o, m_stb_o,        [15:8] slave select (lane 1), [7:0] tx byte (lane 0)
//   m_cyc_o, m_dat_i,
//   m_ack_i
module spi_flash_reader #(
    parameter logic [7:0] SS_ACT  = 8'hFE,
    parameter logic [7:0] SS_IDLE = 8'hFF,
    parameter logic [7:0] RD_CMD  = 8'h03
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] m_dat_o,
    input  logic [7:0]  m_dat_i,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic        m_ack_i
);
    typedef enum logic [3:0] {IDLE, CMD, A2, A1, A0, DATA, WAIT_OUT, DESEL, FIN} state_t;
    state_t      state;
    logic [23:0] addr_r;
    logic [15:0] cnt;
    logic        ack;
    // Acks are only honoured while a transfer is actually requested.
    assign ack     = m_stb_o && m_ack_i;
    assign m_cyc_o = m_stb_o;
    assign m_we_o  = m_stb_o;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            addr_r    <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            m_stb_o   <= 1'b0;
            m_sel_o   <= 2'b00;
            m_dat_o   <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // Dropping stb on ack guarantees an idle cycle before the next
            // transfer, since each state only raises stb while stb is low.
            if (ack)
                m_stb_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && len != 16'd0) begin
                        addr_r <= addr;
                        cnt    <= len;
                        busy   <= 1'b1;
                        state  <= CMD;
                    end else if (start) begin
                        done <= 1'b1;
                    end
                end
                CMD: begin
                    if (!m_stb_o) begin
                        m_stb_o <= 1'b1;
                        m_sel_o <= 2'b11;
                        m_dat_o <= {SS_ACT, RD_CMD};
                    end else if (m_ack_i) begin
                        state <= A2;
                    end
                end
                A2: begin
                    if (!m_stb_o) begin
                        m_stb_o <= 1'b1;
                        m_sel_o <= 2'b01;
                        m_dat_o <= {SS_ACT, addr_r[23:16]};
                    end else if (m_ack_i) begin
                        state <= A1;
                    end
                end
                A1: begin
                    if (!m_stb_o) begin
                        m_stb_o <= 1'b1;
                        m_sel_o <= 2'b01;
                        m_dat_o <= {SS_ACT, addr_r[15:8]};
                    end else if (m_ack_i) begin
                        state <= A0;
                    end
                end
                A0: begin
                    if (!m_stb_o) begin
                        m_stb_o <= 1'b1;
                        m_sel_o <= 2'b01;
                        m_dat_o <= {SS_ACT, addr_r[7:0]};
                    end else if (m_ack_i) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    // A new byte is only fetched once the previous one is gone,
                    // so the output register can never be overwritten.
                    if (!m_stb_o && !out_valid) begin
                        m_stb_o <= 1'b1;
                        m_sel_o <= 2'b01;
                        m_dat_o <= {SS_ACT, 8'hFF};
                    end else if (ack) begin
                        out_data  <= m_dat_i;
                        out_valid <= 1'b1;
                        cnt       <= cnt - 16'd1;
                        state     <= (cnt == 16'd1) ? DESEL : WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (!out_valid || out_ready)
                        state <= DATA;
                end
                DESEL: begin
                    if (!m_stb_o) begin
                        m_stb_o <= 1'b1;
                        m_sel_o <= 2'b10;
                        m_dat_o <= {SS_IDLE, 8'hFF};
                    end else if (m_ack_i) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench for spi_flash_reader with a SPI-core ack model.
module tb_spi_flash_reader;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i, start, out_ready, m_ack_i;
    logic [23:0] addr;
    logic [15:0] len;
    logic [7:0]  m_dat_i;
    logic        busy, done, out_valid, m_we_o, m_stb_o, m_cyc_o;
    logic [7:0]  out_data;
    logic [15:0] m_dat_o;
    logic [1:0]  m_sel_o;
    int          checks = 0, errors = 0;
    int          done_cnt, cyc_hi, viol, ack_num, wcnt, busy_at_done;
    logic [17:0] bus_q[$];
    logic [7:0]  out_q[$];
    spi_flash_reader dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i)
    );
    always #5 wb_clk_i = ~wb_clk_i;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge wb_clk_i);
        #2;
    endtask
    task automatic clear();
        bus_q.delete();
        out_q.delete();
        done_cnt = 0;
        cyc_hi = 0;
        ack_num = 0;
    endtask
    task automatic go(input logic [23:0] a, input logic [15:0] l);
        start = 1'b1;
        addr = a;
        len = l;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    endtask
    // SPI core model: acks the 8th cycle of each strobe, returns A5^transfer index,
    // and logs every acked transfer as {sel, dat}.
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = 8'h00;
        wcnt = 0;
        viol = 0;
        forever begin
            @(negedge wb_clk_i);
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (done) begin
                done_cnt++;
                busy_at_done = 32'(busy);
            end
            if (m_cyc_o) cyc_hi++;
            if (out_valid && m_stb_o) viol++;
            if (m_ack_i) begin
                m_ack_i = 1'b0;
                check("stb_gap_after_ack", 32'(m_stb_o), 0);
            end else if (m_stb_o) begin
                wcnt++;
                if (wcnt == 8) begin
                    m_ack_i = 1'b1;
                    m_dat_i = 8'hA5 ^ 8'(ack_num);
                    bus_q.push_back({m_sel_o, m_dat_o});
                    ack_num++;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end
    initial begin
        logic [17:0] exp1 [7] = '{{2'b11, 16'hFE03}, {2'b01, 16'hFE01}, {2'b01, 16'hFE23},
                                  {2'b01, 16'hFE45}, {2'b01, 16'hFEFF}, {2'b01, 16'hFEFF},
                                  {2'b10, 16'hFFFF}};
        int s;
        start = 1'b0;
        addr = '0;
        len = '0;
        out_ready = 1'b1;
        wb_rst_i = 1'b1;
        clear();
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_stb", 32'(m_stb_o), 0);
        check("rst_cyc", 32'(m_cyc_o), 0);
        check("rst_sel", 32'(m_sel_o), 0);
        check("rst_dat", 32'(m_dat_o), 0);
        wb_rst_i = 1'b0;
        tick();
        // Basic two-byte read.
        clear();
        go(24'h012345, 16'd2);
        check("t1_busy", 32'(busy), 1);
        wait_done("t1", 400);
        check("t1_nxfer", bus_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < bus_q.size()) check($sformatf("t1_xfer%0d", i), 32'(bus_q[i]), 32'(exp1[i]));
        check("t1_nbytes", out_q.size(), 2);
        if (out_q.size() == 2) begin
            check("t1_byte0", 32'(out_q[0]), 32'h A1);
            check("t1_byte1", 32'(out_q[1]), 32'h A0);
        end
        repeat (5) tick();
        check("t1_ndone", done_cnt, 1);
        // Zero-length request.
        clear();
        go(24'h000000, 16'd0);
        check("t2_done", 32'(done), 1);
        check("t2_busy", 32'(busy), 0);
        repeat (20) tick();
        check("t2_ndone", done_cnt, 1);
        check("t2_no_cyc", cyc_hi, 0);
        // Back-pressure: consumer stalls after the first byte.
        clear();
        out_ready = 1'b0;
        go(24'hABCDEF, 16'd3);
        s = 0;
        while (!out_valid && s < 300) begin
            tick();
            s++;
        end
        check("t3_first_byte", 32'(out_valid), 1);
        s = 0;
        repeat (50) begin
            tick();
            if (m_stb_o) s++;
        end
        check("t3_no_stb_hold", s, 0);
        check("t3_valid_held", 32'(out_valid), 1);
        check("t3_data_held", 32'(out_data), 32'hA1);
        out_ready = 1'b1;
        wait_done("t3", 600);
        check("t3_nxfer", bus_q.size(), 8);
        if (bus_q.size() == 8) begin
            check("t3_a0", 32'(bus_q[3]), 32'({2'b01, 16'hFEEF}));
            check("t3_desel", 32'(bus_q[7]), 32'({2'b10, 16'hFFFF}));
        end
        check("t3_nbytes", out_q.size(), 3);
        if (out_q.size() == 3) begin
            check("t3_byte0", 32'(out_q[0]), 32'hA1);
            check("t3_byte1", 32'(out_q[1]), 32'hA0);
            check("t3_byte2", 32'(out_q[2]), 32'hA3);
        end
        check("t3_overlap", viol, 0);
        // Start while busy is ignored.
        clear();
        go(24'h102030, 16'd1);
        repeat (15) tick();
        check("t4_busy", 32'(busy), 1);
        go(24'hFFFFFF, 16'd5);
        wait_done("t4", 400);
        check("t4_nxfer", bus_q.size(), 6);
        if (bus_q.size() == 6) begin
            check("t4_a2", 32'(bus_q[1]), 32'({2'b01, 16'hFE10}));
            check("t4_a1", 32'(bus_q[2]), 32'({2'b01, 16'hFE20}));
            check("t4_a0", 32'(bus_q[3]), 32'({2'b01, 16'hFE30}));
        end
        check("t4_nbytes", out_q.size(), 1);
        cyc_hi = 0;
        repeat (30) tick();
        check("t4_no_restart", cyc_hi, 0);
        check("t4_ndone", done_cnt, 1);
        // Reset during A1 aborts; no deselect transfer follows.
        clear();
        go(24'h445566, 16'd2);
        s = 0;
        while (bus_q.size() < 2 && s < 300) begin
            tick();
            s++;
        end
        repeat (3) tick();
        check("t5_in_a1", 32'(m_dat_o), 32'hFE55);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_stb", 32'(m_stb_o), 0);
        check("t5_cyc", 32'(m_cyc_o), 0);
        check("t5_sel", 32'(m_sel_o), 0);
        check("t5_dat", 32'(m_dat_o), 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_data", 32'(out_data), 0);
        cyc_hi = 0;
        repeat (30) tick();
        check("t5_no_desel", bus_q.size(), 2);
        check("t5_idle_bus", cyc_hi, 0);
        check("t5_ndone", done_cnt, 0);
        clear();
        go(24'h000102, 16'd1);
        wait_done("t5b", 400);
        check("t5b_nxfer", bus_q.size(), 6);
        if (bus_q.size() == 6) begin
            check("t5b_cmd", 32'(bus_q[0]), 32'({2'b11, 16'hFE03}));
            check("t5b_a0", 32'(bus_q[3]), 32'({2'b01, 16'hFE02}));
        end
        check("t5b_nbytes", out_q.size(), 1);
        if (out_q.size() == 1) check("t5b_byte0", 32'(out_q[0]), 32'hA1);
        check("overlap_total", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
